// File: rtl/fir_ctrl_pkg.sv
// Shared constants and FSM encoding for the FIR coefficient loader, filter and ROM wrapper.
package fir_ctrl_pkg;

  localparam int FIR_NCOEF   = 62;
  localparam int FIR_COEF_AW = 7;
  localparam int FIR_BANK_W  = 1;
  localparam int FIR_DW      = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'b000,
    ST_SET_ADDR  = 3'b001,
    ST_READ_ROM  = 3'b010,
    ST_WRITE_RAM = 3'b011,
    ST_DEC       = 3'b100,
    ST_DONE      = 3'b101
  } ctrl_state_e;

endpackage

// File: rtl/coef_index_counter.sv
// Loadable down-counter for the coefficient index; saturates at zero instead of wrapping.
module coef_index_counter #(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_val,
  input  logic          dec_en,
  output logic [AW-1:0] count,
  output logic          is_zero
);

  logic [AW-1:0] count_r;

  // index register: load has priority over decrement
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= {AW{1'b0}};
    end else if (load_en) begin
      count_r <= load_val;
    end else if (dec_en && (count_r != {AW{1'b0}})) begin
      count_r <= count_r - {{(AW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count   = count_r;
  assign is_zero = (count_r == {AW{1'b0}});

endmodule

// File: rtl/coef_load_ctrl.sv
// Copies one coefficient bank from ROM into the filter's coefficient RAM and gates
// the filter while the RAM contents are inconsistent; queues one request during a load.
module coef_load_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int NCOEF   = FIR_NCOEF,
  parameter int COEF_AW = FIR_COEF_AW,
  parameter int BANK_W  = FIR_BANK_W,
  parameter int DW      = FIR_DW
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_i,
  input  logic [BANK_W-1:0]         bank_i,
  input  logic                      sample_valid_i,
  output logic [BANK_W+COEF_AW-1:0] rom_addr_o,
  input  logic [DW-1:0]             rom_data_i,
  output logic [COEF_AW-1:0]        ram_addr_o,
  output logic [DW-1:0]             ram_data_o,
  output logic                      ram_wren_o,
  output logic                      filter_en_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      coef_valid_o,
  output logic [BANK_W-1:0]         active_bank_o
);

  localparam logic [COEF_AW-1:0] LAST_IDX = COEF_AW'(NCOEF - 1);

  ctrl_state_e         state_r, state_s;
  logic [BANK_W-1:0]   bank_r, pend_bank_r, active_bank_r;
  logic                pend_r, coef_valid_r;
  logic                idx_load_s, idx_dec_s, idx_zero_s;
  logic [COEF_AW-1:0]  idx_s;

  coef_index_counter #(.AW(COEF_AW)) u_idx (
    .clk      (clk),
    .reset    (reset),
    .load_en  (idx_load_s),
    .load_val (LAST_IDX),
    .dec_en   (idx_dec_s),
    .count    (idx_s),
    .is_zero  (idx_zero_s)
  );

  // next-state and index counter control
  always_comb begin
    state_s    = state_r;
    idx_load_s = 1'b0;
    idx_dec_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_s    = ST_SET_ADDR;
          idx_load_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SET_ADDR:  state_s = ST_READ_ROM;
      ST_READ_ROM:  state_s = ST_WRITE_RAM;
      ST_WRITE_RAM: state_s = ST_DEC;
      ST_DEC: begin
        if (idx_zero_s) begin
          state_s = ST_DONE;
        end else begin
          idx_dec_s = 1'b1;
          state_s   = ST_SET_ADDR;
        end
      end
      ST_DONE: begin
        // a request arriving in DONE itself chains straight into the next load
        if (pend_r || start_i) begin
          state_s    = ST_SET_ADDR;
          idx_load_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // state, bank, pending-request and validity registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      bank_r        <= {BANK_W{1'b0}};
      pend_r        <= 1'b0;
      pend_bank_r   <= {BANK_W{1'b0}};
      coef_valid_r  <= 1'b0;
      active_bank_r <= {BANK_W{1'b0}};
    end else begin
      state_r <= state_s;
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            bank_r       <= bank_i;
            coef_valid_r <= 1'b0;
          end
        end
        ST_DONE: begin
          active_bank_r <= bank_r;
          if (pend_r) begin
            bank_r       <= pend_bank_r;
            pend_r       <= start_i;
            pend_bank_r  <= start_i ? bank_i : pend_bank_r;
            coef_valid_r <= 1'b0;
          end else if (start_i) begin
            bank_r       <= bank_i;
            coef_valid_r <= 1'b0;
          end else begin
            coef_valid_r <= 1'b1;
          end
        end
        default: begin
          if (start_i) begin
            pend_r      <= 1'b1;
            pend_bank_r <= bank_i;
          end
        end
      endcase
    end
  end

  // output decode from registered state; buses are forced to zero outside their window
  always_comb begin
    busy_o        = (state_r != ST_IDLE);
    done_o        = (state_r == ST_DONE);
    ram_wren_o    = (state_r == ST_WRITE_RAM);
    filter_en_o   = sample_valid_i & coef_valid_r & (state_r == ST_IDLE);
    coef_valid_o  = coef_valid_r;
    active_bank_o = active_bank_r;
    if ((state_r == ST_SET_ADDR) || (state_r == ST_READ_ROM)) begin
      rom_addr_o = {bank_r, idx_s};
    end else begin
      rom_addr_o = {(BANK_W+COEF_AW){1'b0}};
    end
    if (state_r == ST_WRITE_RAM) begin
      ram_addr_o = idx_s;
      ram_data_o = rom_data_i;
    end else begin
      ram_addr_o = {COEF_AW{1'b0}};
      ram_data_o = {DW{1'b0}};
    end
  end

endmodule

// File: tb/tb_coef_load_ctrl.sv
// Directed bench for coef_load_ctrl: a 4-coefficient instance and a default 62-coefficient
// instance, each fed by a 1-cycle-latency ROM model returning address + 0x100.
module tb_coef_load_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        sv;
  logic        start4, start62;
  logic [0:0]  bank4, bank62;
  logic [7:0]  rom_addr4, rom_addr62;
  logic [15:0] rom4_q, rom62_q;
  logic [6:0]  ram_addr4, ram_addr62;
  logic [15:0] ram_data4, ram_data62;
  logic        wren4, wren62, fen4, fen62, busy4, busy62, done4, done62, cv4, cv62;
  logic [0:0]  ab4, ab62;

  int n_cmp = 0;
  int n_err = 0;
  int writes, dones;

  always_ff @(posedge clk) begin
    rom4_q  <= 16'h0100 + {8'h00, rom_addr4};
    rom62_q <= 16'h0100 + {8'h00, rom_addr62};
  end

  coef_load_ctrl #(.NCOEF(4)) dut4 (
    .clk(clk), .reset(reset), .start_i(start4), .bank_i(bank4), .sample_valid_i(sv),
    .rom_addr_o(rom_addr4), .rom_data_i(rom4_q), .ram_addr_o(ram_addr4),
    .ram_data_o(ram_data4), .ram_wren_o(wren4), .filter_en_o(fen4), .busy_o(busy4),
    .done_o(done4), .coef_valid_o(cv4), .active_bank_o(ab4)
  );

  coef_load_ctrl dut62 (
    .clk(clk), .reset(reset), .start_i(start62), .bank_i(bank62), .sample_valid_i(sv),
    .rom_addr_o(rom_addr62), .rom_data_i(rom62_q), .ram_addr_o(ram_addr62),
    .ram_data_o(ram_data62), .ram_wren_o(wren62), .filter_en_o(fen62), .busy_o(busy62),
    .done_o(done62), .coef_valid_o(cv62), .active_bank_o(ab62)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset4(input string tag);
    chk({tag, "_busy"},  32'(busy4), 32'd0);
    chk({tag, "_done"},  32'(done4), 32'd0);
    chk({tag, "_wren"},  32'(wren4), 32'd0);
    chk({tag, "_cv"},    32'(cv4), 32'd0);
    chk({tag, "_fen"},   32'(fen4), 32'd0);
    chk({tag, "_ab"},    32'(ab4), 32'd0);
    chk({tag, "_rom"},   32'(rom_addr4), 32'd0);
    chk({tag, "_raddr"}, 32'(ram_addr4), 32'd0);
    chk({tag, "_rdata"}, 32'(ram_data4), 32'd0);
  endtask

  initial begin
    reset = 1'b0; sv = 1'b1;
    start4 = 1'b0; bank4 = 1'b0; start62 = 1'b0; bank62 = 1'b0;
    step(); step(); step();
    chk_reset4("rst");
    reset = 1'b1;
    step();
    chk("pre_fen", 32'(fen4), 32'd0);

    // basic bank-0 load, NCOEF=4: writes at 3,7,11,15, done at 17
    bank4 = 1'b0; start4 = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      step();
      start4 = 1'b0;
      chk("t1_busy", 32'(busy4), 32'((c >= 1) && (c <= 17)));
      chk("t1_done", 32'(done4), 32'(c == 17));
      chk("t1_wren", 32'(wren4), 32'((c <= 15) && (c % 4 == 3)));
      if ((c <= 15) && (c % 4 == 3)) begin
        chk("t1_raddr", 32'(ram_addr4), 32'(3 - (c - 3) / 4));
        chk("t1_rdata", 32'(ram_data4), 32'(16'h0100 + 3 - (c - 3) / 4));
      end
      if (c % 4 == 1 && c <= 13)
        chk("t1_rom", 32'(rom_addr4), 32'(3 - (c - 1) / 4));
      chk("t1_fen", 32'(fen4), 32'(c == 18));
    end
    chk("t1_cv", 32'(cv4), 32'd1);
    chk("t1_ab", 32'(ab4), 32'd0);

    // two requests mid-load: last bank (0) wins, one extra load from cycle 18
    bank4 = 1'b0; start4 = 1'b1;
    writes = 0; dones = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      start4 = (c == 5) || (c == 9);
      bank4  = (c == 5) ? 1'b1 : 1'b0;
      if (c == 13) chk("t3_rom_first", 32'(rom_addr4), 32'h00);
      if (c == 17) chk("t3_done1", 32'(done4), 32'd1);
      if (c == 18) begin
        chk("t3_busy18", 32'(busy4), 32'd1);
        chk("t3_rom18", 32'(rom_addr4), 32'h03);
        chk("t3_cv18", 32'(cv4), 32'd0);
      end
      if (c >= 18) begin
        writes += int'(wren4);
        dones  += int'(done4);
      end
      if (c == 34) chk("t3_done2", 32'(done4), 32'd1);
      if (c == 35) chk("t3_fen35", 32'(fen4), 32'd1);
    end
    chk("t3_writes", 32'(writes), 32'd4);
    chk("t3_dones", 32'(dones), 32'd1);
    chk("t3_busy", 32'(busy4), 32'd0);
    chk("t3_ab", 32'(ab4), 32'd0);
    chk("t3_cv", 32'(cv4), 32'd1);

    // request exactly in DONE chains a bank-1 reload at DONE+1
    bank4 = 1'b0; start4 = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      step();
      start4 = (c == 17);
      bank4  = (c == 17) ? 1'b1 : 1'b0;
      if (c == 17) begin
        chk("t6_done", 32'(done4), 32'd1);
        chk("t6_cv17", 32'(cv4), 32'd0);
      end
      if (c == 18) begin
        chk("t6_busy18", 32'(busy4), 32'd1);
        chk("t6_rom18", 32'(rom_addr4), 32'h83);
        chk("t6_cv18", 32'(cv4), 32'd0);
      end
      if (c == 34) chk("t6_done2", 32'(done4), 32'd1);
      if (c == 35) begin
        chk("t6_busy35", 32'(busy4), 32'd0);
        chk("t6_cv35", 32'(cv4), 32'd1);
        chk("t6_ab35", 32'(ab4), 32'd1);
        chk("t6_fen35", 32'(fen4), 32'd1);
      end
    end

    // full default-size load of bank 1
    bank62 = 1'b1; start62 = 1'b1;
    writes = 0; dones = 0;
    for (int c = 1; c <= 251; c++) begin
      step();
      start62 = 1'b0;
      writes += int'(wren62);
      dones  += int'(done62);
      chk("t2_done", 32'(done62), 32'(c == 249));
      if ((c <= 247) && (c % 4 == 3)) begin
        chk("t2_raddr", 32'(ram_addr62), 32'(61 - (c - 3) / 4));
        chk("t2_rdata", 32'(ram_data62), 32'(16'h0180 + 61 - (c - 3) / 4));
      end
      if ((c <= 246) && ((c % 4 == 1) || (c % 4 == 2)))
        chk("t2_rom_msb", 32'(rom_addr62[7]), 32'd1);
      if (c <= 249) chk("t2_fen", 32'(fen62), 32'd0);
    end
    chk("t2_writes", 32'(writes), 32'd62);
    chk("t2_dones", 32'(dones), 32'd1);
    chk("t2_ab", 32'(ab62), 32'd1);
    chk("t2_cv", 32'(cv62), 32'd1);

    // reset at cycle 8 aborts the load
    bank4 = 1'b1; start4 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      start4 = 1'b0;
      if (c == 7) chk("t5_wren7", 32'(wren4), 32'd1);
      if (c == 8) reset = 1'b0;
      if (c == 9) begin
        chk_reset4("t5");
        reset = 1'b1;
      end
      if (c >= 9) begin
        chk("t5_nowren", 32'(wren4), 32'd0);
        chk("t5_cv", 32'(cv4), 32'd0);
        chk("t5_busy", 32'(busy4), 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
